mac_sequencer: RTL and testbench

Sequential multiply-accumulate controller wrapped around the combinational 4x4 array multiplier. It accepts 4-bit operand pairs over a valid/ready handshake and drives them onto the multiplier inputs as registered values. It samples the 8-bit product and accumulates products into an ACC_W-bit result. A finished result is presented downstream over a second valid/ready handshake.

---
 rtl/mac_sequencer_if.sv | 39 +++
 rtl/mac_sequencer.sv | 138 +++++++++++++
 tb/tb_mac_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand, multiplier and result signals of the MAC
// sequencer.
//
// Handshake rule for both channels (in_* and out_*): a transfer happens on a
// rising clk edge where valid && ready are both 1. The valid side holds its
// payload stable until that edge. ready may depend on state and enable but
// never on valid.
//
// mul_a/mul_b/mul_p connect to the external combinational 4x4 multiplier.
// The sequencer drives mul_a/mul_b. The multiplier drives mul_p.
interface mac_sequencer_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_count;
  logic             ovf;

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_acc, out_count, ovf
  );

  // Environment side: operand source, multiplier and result sink.
  modport master (
    output in_valid, in_a, in_b, in_last, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_acc, out_count, ovf
  );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequential multiply-accumulate controller around an
// external combinational 4x4 multiplier.
//
// Flow:
// - IDLE accepts an operand pair and registers it onto mul_a/mul_b.
// - MUL samples the settled product.
// - ACC adds the product into the accumulator.
// - DONE holds the finished group result until it is consumed.
//
// The operand pair is marked last with in_last. A pair without in_last
// returns to IDLE after ACC. A pair with in_last goes on to DONE.
//
// Build option: define MAC_SAT_EN to make the accumulator saturate at
// 2^ACC_W-1 instead of wrapping. The ovf flag is set on any carry-out in
// both builds.
//
// ACC_W legal range: 8..24.
module mac_sequencer #(
  parameter int ACC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  mac_sequencer_if.slave      bus,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [3:0]       mul_a_q;
  logic [3:0]       mul_b_q;
  logic [7:0]       prod_q;
  logic             last_q;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_q;

  logic             accept;
  logic             consume;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;

  // Handshake outputs are gated by ena so no transfer can complete while
  // frozen.
  assign bus.in_ready  = ena && (state == IDLE);
  assign bus.out_valid = ena && (state == DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign consume       = bus.out_valid && bus.out_ready;

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_acc   = acc;
  assign bus.out_count = cnt;
  assign bus.ovf       = ovf_q;
  assign state_dbg     = state;

  // Zero-extended product and one-bit-wider sum; sum[ACC_W] is the carry-out.
  assign prod_ext = {{(ACC_W-7){1'b0}}, prod_q};

  // Full-width add of the registered product into the accumulator.
  always_comb begin
    sum = {1'b0, acc} + prod_ext;
  end

`ifdef MAC_SAT_EN
  // On carry-out, clamp to the maximum so that later adds stay pinned there.
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  // Drop the carry: the accumulator wraps modulo 2^ACC_W.
  assign acc_next = sum[ACC_W-1:0];
`endif

  // Control FSM: IDLE -> MUL -> ACC -> (IDLE | DONE), DONE -> IDLE on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      case (state)
        IDLE: if (accept) state <= MUL;
        MUL:  state <= ACC;
        ACC:  state <= last_q ? DONE : IDLE;
        DONE: if (consume) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and product registers.
  // Only an accept changes mul_a/mul_b, so the multiplier inputs stay put
  // through MUL, ACC and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= 4'd0;
      mul_b_q <= 4'd0;
      last_q  <= 1'b0;
      prod_q  <= 8'd0;
    end else if (ena) begin
      if (accept) begin
        mul_a_q <= bus.in_a;
        mul_b_q <= bus.in_b;
        last_q  <= bus.in_last;
      end
      if (state == MUL) begin
        prod_q <= bus.mul_p;
      end
    end
  end

  // Accumulator, product count and sticky overflow for the current group.
  // All three are cleared when the finished result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= 8'd0;
      ovf_q <= 1'b0;
    end else if (ena) begin
      if (state == ACC) begin
        acc <= acc_next;
        if (sum[ACC_W]) begin
          ovf_q <= 1'b1;
        end
        if (cnt != 8'hFF) begin
          cnt <= cnt + 8'd1;
        end
      end else if (consume) begin
        acc   <= '0;
        cnt   <= 8'd0;
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: bench for mac_sequencer.
//
// Two instances run in lockstep from the same stimulus: ACC_W=16 and ACC_W=8.
// A group-level arithmetic model predicts each finished result and queues it.
// Every consume is compared against that queue.
// Directed table vectors and hand-written sequences cover latency, the
// backpressure hold, overflow, mid-group reset and enable freeze.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic [1:0] st16;
  logic [1:0] st8;

  int n_cmp = 0;
  int n_fail = 0;
  int n_consumed = 0;
  bit rnd_ready = 1'b0;

  // Expected result record:
  // {ovf8, acc8[7:0], ovf16, acc16[15:0], cnt[7:0]}
  logic [33:0] exp_q[$];

  // Group model state for both accumulator widths.
  int m_acc16 = 0;
  int m_acc8 = 0;
  int m_cnt = 0;
  bit m_ovf16 = 1'b0;
  bit m_ovf8 = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       last;
    int         exp_acc;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[7];

  // Clock generation.
  always #5 clk = ~clk;

  mac_sequencer_if #(.ACC_W(16)) ifc16();
  mac_sequencer_if #(.ACC_W(8))  ifc8();

  // Stimulus fan-out to both instances.
  // Each instance has its own combinational multiplier.
  assign ifc16.in_valid  = in_valid;
  assign ifc16.in_a      = in_a;
  assign ifc16.in_b      = in_b;
  assign ifc16.in_last   = in_last;
  assign ifc16.out_ready = out_ready;
  assign ifc16.mul_p     = {4'd0, ifc16.mul_a} * {4'd0, ifc16.mul_b};
  assign ifc8.in_valid   = in_valid;
  assign ifc8.in_a       = in_a;
  assign ifc8.in_b       = in_b;
  assign ifc8.in_last    = in_last;
  assign ifc8.out_ready  = out_ready;
  assign ifc8.mul_p      = {4'd0, ifc8.mul_a} * {4'd0, ifc8.mul_b};

  mac_sequencer #(.ACC_W(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (ifc16.slave),
    .state_dbg (st16)
  );

  mac_sequencer #(.ACC_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (ifc8.slave),
    .state_dbg (st8)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Fold a raw sum into a w-bit accumulator following the configured policy.
  function automatic int fold(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef MAC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  function automatic void model_reset();
    m_acc16 = 0;
    m_acc8  = 0;
    m_cnt   = 0;
    m_ovf16 = 1'b0;
    m_ovf8  = 1'b0;
  endfunction

  // Add one accepted pair to the group; queue the result when it is last.
  function automatic void model_accept(input logic [3:0] a, input logic [3:0] b,
                                       input logic last);
    int p;
    logic [15:0] r16;
    logic [7:0]  r8;
    logic [7:0]  rc;
    p = int'(a) * int'(b);
    if (m_acc16 + p > 65535) m_ovf16 = 1'b1;
    if (m_acc8 + p > 255)    m_ovf8 = 1'b1;
    m_acc16 = fold(m_acc16 + p, 16);
    m_acc8  = fold(m_acc8 + p, 8);
    m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (last) begin
      r16 = m_acc16[15:0];
      r8  = m_acc8[7:0];
      rc  = m_cnt[7:0];
      exp_q.push_back({m_ovf8, r8, m_ovf16, r16, rc});
      model_reset();
    end
  endfunction

  // Scoreboard.
  // A consume happens at the next rising edge whenever out_valid && out_ready
  // holds at the falling edge, because inputs only change just after rising
  // edges.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && ifc16.out_valid && out_ready) begin
      n_consumed++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got result acc=%0d expected none",
                 ifc16.out_acc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_cnt16", 32'(ifc16.out_count), 32'(e[7:0]));
        chk("sb_acc16", 32'(ifc16.out_acc), 32'(e[23:8]));
        chk("sb_ovf16", 32'(ifc16.ovf), 32'(e[24]));
        chk("sb_valid8", 32'(ifc8.out_valid), 32'd1);
        chk("sb_acc8", 32'(ifc8.out_acc), 32'(e[32:25]));
        chk("sb_ovf8", 32'(ifc8.ovf), 32'(e[33]));
        chk("sb_cnt8", 32'(ifc8.out_count), 32'(e[7:0]));
      end
    end
  end

  // Random result backpressure during the random phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Wait for in_ready, present the pair, and return 1 time unit after the
  // accepting edge.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b,
                           input logic last);
    int t;
    t = 0;
    @(negedge clk);
    while (!ifc16.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ifc16.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_accept(a, b, last);
  endtask

  // Return at the first falling edge that shows out_valid.
  task automatic wait_valid(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!ifc16.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ifc16.out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
    end
  endtask

  task automatic expect_result(input string name, input int acc,
                               input int cnt, input logic o);
    wait_valid(name);
    chk({name, "_acc"}, 32'(ifc16.out_acc), 32'(acc));
    chk({name, "_cnt"}, 32'(ifc16.out_count), 32'(cnt));
    chk({name, "_ovf"}, 32'(ifc16.ovf), 32'(o));
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int t;
    int n;

    vecs[0] = '{4'd15, 4'd15, 1'b1, 225, 1};
    vecs[1] = '{4'd3,  4'd4,  1'b0, 0,   0};
    vecs[2] = '{4'd5,  4'd6,  1'b0, 0,   0};
    vecs[3] = '{4'd7,  4'd2,  1'b1, 56,  3};
    vecs[4] = '{4'd1,  4'd0,  1'b1, 0,   1};
    vecs[5] = '{4'd0,  4'd15, 1'b0, 0,   0};
    vecs[6] = '{4'd8,  4'd8,  1'b1, 64,  2};

    // Reset values, and in_ready following ena during reset.
    ena = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ifc16.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ifc16.out_valid), 32'd0);
    chk("rst_out_acc", 32'(ifc16.out_acc), 32'd0);
    chk("rst_out_count", 32'(ifc16.out_count), 32'd0);
    chk("rst_ovf", 32'(ifc16.ovf), 32'd0);
    chk("rst_mul_a", 32'(ifc16.mul_a), 32'd0);
    chk("rst_mul_b", 32'(ifc16.mul_b), 32'd0);
    ena = 1'b0;
    #1;
    chk("rst_in_ready_ena0", 32'(ifc16.in_ready), 32'd0);
    ena = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Table vectors, with latency checks on each last pair.
    for (int i = 0; i < 7; i++) begin
      send_pair(vecs[i].a, vecs[i].b, vecs[i].last);
      @(negedge clk);
      chk("vec_mul_a", 32'(ifc16.mul_a), 32'(vecs[i].a));
      chk("vec_mul_b", 32'(ifc16.mul_b), 32'(vecs[i].b));
      if (vecs[i].last) begin
        chk("vec_valid_k0", 32'(ifc16.out_valid), 32'd0);
        @(negedge clk);
        chk("vec_valid_k1", 32'(ifc16.out_valid), 32'd0);
        @(negedge clk);
        chk("vec_valid_k2", 32'(ifc16.out_valid), 32'd1);
        chk("vec_acc", 32'(ifc16.out_acc), 32'(vecs[i].exp_acc));
        chk("vec_cnt", 32'(ifc16.out_count), 32'(vecs[i].exp_cnt));
        chk("vec_ovf", 32'(ifc16.ovf), 32'd0);
        @(negedge clk);
        chk("vec_in_ready_after", 32'(ifc16.in_ready), 32'd1);
        chk("vec_valid_after", 32'(ifc16.out_valid), 32'd0);
      end
    end

    // Result held 10 cycles under backpressure; in_valid pulses are ignored.
    out_ready = 1'b0;
    send_pair(4'd1, 4'd2, 1'b1);
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(ifc16.out_valid), 32'd1);
      chk("hold_acc", 32'(ifc16.out_acc), 32'd2);
      chk("hold_cnt", 32'(ifc16.out_count), 32'd1);
      chk("hold_in_ready", 32'(ifc16.in_ready), 32'd0);
      in_valid = 1'b1;
      in_a     = 4'($urandom_range(0, 15));
      in_b     = 4'($urandom_range(0, 15));
      in_last  = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    c0 = n_consumed;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_consume_once", 32'(n_consumed - c0), 32'd1);
    chk("hold_in_ready_after", 32'(ifc16.in_ready), 32'd1);
    chk("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overflow with (15,15),(15,15,last).
    // 450 for the 16-bit instance; 8-bit either saturates or wraps.
    send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
    wait_valid("ovf8");
`ifdef MAC_SAT_EN
    chk("ovf8_acc", 32'(ifc8.out_acc), 32'd255);
`else
    chk("ovf8_acc", 32'(ifc8.out_acc), 32'd194);
`endif
    chk("ovf8_ovf", 32'(ifc8.ovf), 32'd1);
    chk("ovf16_acc", 32'(ifc16.out_acc), 32'd450);
    chk("ovf16_ovf", 32'(ifc16.ovf), 32'd0);

    // Reset in MUL discards a partial group; outputs drop without a clock.
    send_pair(4'd9, 4'd9, 1'b0);
    send_pair(4'd4, 4'd4, 1'b0);
    @(negedge clk);
    chk("mid_pre_acc", 32'(ifc16.out_acc), 32'd81);
    chk("mid_pre_cnt", 32'(ifc16.out_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mul_a", 32'(ifc16.mul_a), 32'd0);
    chk("mid_rst_mul_b", 32'(ifc16.mul_b), 32'd0);
    chk("mid_rst_acc", 32'(ifc16.out_acc), 32'd0);
    chk("mid_rst_cnt", 32'(ifc16.out_count), 32'd0);
    chk("mid_rst_in_ready", 32'(ifc16.in_ready), 32'd1);
    chk("mid_rst_valid", 32'(ifc16.out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(4'd2, 4'd3, 1'b1);
    expect_result("after_rst", 6, 1, 1'b0);

    // ena low for 5 cycles while in ACC.
    send_pair(4'd5, 4'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_in_ready", 32'(ifc16.in_ready), 32'd0);
      chk("frz_valid", 32'(ifc16.out_valid), 32'd0);
      chk("frz_acc", 32'(ifc16.out_acc), 32'd0);
      chk("frz_mul_a", 32'(ifc16.mul_a), 32'd5);
    end
    ena = 1'b1;
    expect_result("frz", 25, 1, 1'b0);

    // Long group: 300 products of 225.
    // The count saturates at 255, and the 16-bit accumulator overflows.
    for (int i = 0; i < 299; i++) send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
`ifdef MAC_SAT_EN
    expect_result("long", 65535, 255, 1'b1);
`else
    expect_result("long", 1964, 255, 1'b1);
`endif

    // Random groups against the model, with random backpressure.
    @(negedge clk);
    rnd_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        send_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  (j == n - 1) ? 1'b1 : 1'b0);
      end
    end
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_in_ready", 32'(ifc16.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
